// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle signed multiply/divide unit.
// Optional divide-by-zero trap is controlled by MULT_DIV_ZERO_EXC_EN in mult_div_unit.
package mult_div_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ITERATIONS = WIDTH_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FIX,
        ST_DZERO,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP,
        BOOTH_ADD,
        BOOTH_SUB
    } booth_op_t;

    // Radix-2 Booth recoding of {Q[0], q_-1}
    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b10:   return BOOTH_SUB;
            2'b01:   return BOOTH_ADD;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the
// divisor magnitude, keep the difference only if it did not go negative.
module div_restore_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_new,
    output logic [WIDTH-1:0] q_new
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] trial;

    // R < |b| <= 2^(WIDTH-1), so the shifted remainder never reaches bit WIDTH
    assign r_shift = {r, q[WIDTH-1]};
    assign trial   = r_shift - {1'b0, d};

    always_comb begin
        if (trial[WIDTH]) begin
            r_new = r_shift[WIDTH-1:0];
            q_new = {q[WIDTH-2:0], 1'b0};
        end else begin
            r_new = trial[WIDTH-1:0];
            q_new = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed Booth multiply / restoring divide with hi/lo result registers.
// Define MULT_DIV_ZERO_EXC_EN to trap division by zero via the div_zero pulse.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
`ifdef MULT_DIV_ZERO_EXC_EN
    output logic             div_zero,
`endif
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH:0]   acc_reg, acc_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             qm1_reg, qm1_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             sign_a_reg, sign_a_next;
    logic             sign_b_reg, sign_b_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             dz_reg, dz_next;
    logic             div_zero_reg, div_zero_next;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] div_r, div_q;

    // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude
    assign a_abs = a_in[WIDTH-1] ? -a_in : a_in;
    assign b_abs = b_in[WIDTH-1] ? -b_in : b_in;

    div_restore_step #(.WIDTH(WIDTH)) u_div_step (
        .r     (acc_reg[WIDTH-1:0]),
        .q     (q_reg),
        .d     (m_reg),
        .r_new (div_r),
        .q_new (div_q)
    );

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        q_next        = q_reg;
        qm1_next      = qm1_reg;
        m_next        = m_reg;
        cnt_next      = cnt_reg;
        sign_a_next   = sign_a_reg;
        sign_b_next   = sign_b_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        dz_next       = dz_reg;
        done_next     = 1'b0;
        div_zero_next = 1'b0;
        booth_sum     = acc_reg;

        case (state_reg)
            ST_IDLE: begin
                if (mult_start) begin
                    state_next = ST_MULT;
                    acc_next   = '0;
                    q_next     = b_in;
                    qm1_next   = 1'b0;
                    m_next     = a_in;
                    cnt_next   = '0;
                    dz_next    = 1'b0;
                end else if (div_start) begin
                    acc_next    = '0;
                    q_next      = a_abs;
                    qm1_next    = 1'b0;
                    m_next      = b_abs;
                    cnt_next    = '0;
                    sign_a_next = a_in[WIDTH-1];
                    sign_b_next = b_in[WIDTH-1];
`ifdef MULT_DIV_ZERO_EXC_EN
                    dz_next    = (b_in == '0);
                    state_next = (b_in == '0) ? ST_DZERO : ST_DIV;
`else
                    dz_next    = 1'b0;
                    state_next = ST_DIV;
`endif
                end
            end
            ST_MULT: begin
                case (booth_decode(q_reg[0], qm1_reg))
                    BOOTH_ADD: booth_sum = acc_reg + {m_reg[WIDTH-1], m_reg};
                    BOOTH_SUB: booth_sum = acc_reg - {m_reg[WIDTH-1], m_reg};
                    default:   booth_sum = acc_reg;
                endcase
                acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                q_next   = {booth_sum[0], q_reg[WIDTH-1:1]};
                qm1_next = q_reg[0];
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_STEP)
                    state_next = ST_DONE;
            end
            ST_DIV: begin
                acc_next = {1'b0, div_r};
                q_next   = div_q;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_STEP)
                    state_next = ST_FIX;
            end
            ST_FIX: begin
                q_next     = (sign_a_reg ^ sign_b_reg) ? -q_reg : q_reg;
                acc_next   = {1'b0, sign_a_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0]};
                state_next = ST_DONE;
            end
            ST_DZERO: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done_next     = 1'b1;
                div_zero_next = dz_reg;
                if (!dz_reg) begin
                    hi_next = acc_reg[WIDTH-1:0];
                    lo_next = q_reg;
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            acc_reg      <= '0;
            q_reg        <= '0;
            qm1_reg      <= 1'b0;
            m_reg        <= '0;
            cnt_reg      <= '0;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            dz_reg       <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            q_reg        <= q_next;
            qm1_reg      <= qm1_next;
            m_reg        <= m_next;
            cnt_reg      <= cnt_next;
            sign_a_reg   <= sign_a_next;
            sign_b_reg   <= sign_b_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            dz_reg       <= dz_next;
            div_zero_reg <= div_zero_next;
        end
    end

    assign hi   = hi_reg;
    assign lo   = lo_reg;
    assign busy = busy_reg;
    assign done = done_reg;
`ifdef MULT_DIV_ZERO_EXC_EN
    assign div_zero = div_zero_reg;
`else
    logic unused_dz;
    assign unused_dz = div_zero_reg;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: table of operations with hand-computed
// results and latencies, plus sequences for start collision, busy-ignore and reset.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
`ifdef MULT_DIV_ZERO_EXC_EN
    logic        div_zero;
`endif

    int tests;
    int fails;

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a_in       (a_in),
        .b_in       (b_in),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
`ifdef MULT_DIV_ZERO_EXC_EN
        .div_zero   (div_zero),
`endif
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_mult;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        logic        dz;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives a start so that it is sampled at the next rising edge (E0); returns just after E0
    task automatic launch(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mult_start = m;
        div_start  = d;
        a_in       = a;
        b_in       = b;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a_in       = 32'hDEADBEEF;
        b_in       = 32'hCAFEF00D;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        tests      = 0;
        fails      = 0;
        reset      = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a_in       = '0;
        b_in       = '0;

        vecs[0]  = '{1'b1, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0};
        vecs[1]  = '{1'b1, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 33, 1'b0};
        vecs[2]  = '{1'b1, 32'h00010000,  32'h00010000, 32'h00000001, 32'h00000000, 33, 1'b0};
        vecs[3]  = '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 1'b0};
        vecs[4]  = '{1'b1, 32'h7FFFFFFF,  32'd2,        32'h00000000, 32'hFFFFFFFE, 33, 1'b0};
        vecs[5]  = '{1'b0, 32'd7,         32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34, 1'b0};
        vecs[6]  = '{1'b0, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b0};
        vecs[7]  = '{1'b0, 32'd100,       32'd7,        32'h00000002, 32'h0000000E, 34, 1'b0};
        vecs[8]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 1'b0};
        vecs[9]  = '{1'b0, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 34, 1'b0};
`ifdef MULT_DIV_ZERO_EXC_EN
        vecs[10] = '{1'b0, 32'h12345678,  32'd0,        32'hFFFFFFFE, 32'h0000000E, 2,  1'b1};
        vecs[11] = '{1'b0, 32'hFFFFFFFB,  32'd0,        32'hFFFFFFFE, 32'h0000000E, 2,  1'b1};
`else
        vecs[10] = '{1'b0, 32'h12345678,  32'd0,        32'h12345678, 32'hFFFFFFFF, 34, 1'b0};
        vecs[11] = '{1'b0, 32'hFFFFFFFB,  32'd0,        32'hFFFFFFFB, 32'h00000001, 34, 1'b0};
`endif

        repeat (2) @(posedge clk);
        #1;
        check("reset_hi",   {32'd0, hi}, 64'd0);
        check("reset_lo",   {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].is_mult, !vecs[i].is_mult, vecs[i].a, vecs[i].b);
            check("busy_at_e0", {63'd0, busy}, 64'd1);
            check("done_fell",  {63'd0, done}, 64'd0);
            wait_done(100, n);
            check("latency", 64'(n), 64'(vecs[i].lat));
            check("hi", {32'd0, hi}, {32'd0, vecs[i].hi});
            check("lo", {32'd0, lo}, {32'd0, vecs[i].lo});
            check("busy_at_done", {63'd0, busy}, 64'd0);
`ifdef MULT_DIV_ZERO_EXC_EN
            check("div_zero", {63'd0, div_zero}, {63'd0, vecs[i].dz});
`endif
            $display("[TB] vec %0d %s a=%h b=%h -> hi=%h lo=%h lat=%0d",
                     i, vecs[i].is_mult ? "mult" : "div ", vecs[i].a, vecs[i].b, hi, lo, n);
        end

        // Simultaneous starts: multiply must win
        launch(1'b1, 1'b1, 32'd3, 32'd5);
        wait_done(100, n);
        check("both_latency", 64'(n), 64'd33);
        check("both_hi", {32'd0, hi}, 64'd0);
        check("both_lo", {32'd0, lo}, 64'd15);
        $display("[TB] both starts a=3 b=5 -> hi=%h lo=%h lat=%0d", hi, lo, n);

        // Start while busy is ignored and not queued
        launch(1'b1, 1'b0, 32'd9, 32'd9);
        repeat (4) @(posedge clk);
        @(negedge clk);
        div_start = 1'b1;
        a_in      = 32'd100;
        b_in      = 32'd7;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        wait_done(100, n);
        check("ignore_latency", 64'(n), 64'd28);
        check("ignore_lo", {32'd0, lo}, 64'd81);
        check("ignore_hi", {32'd0, hi}, 64'd0);
        wait_done(40, n);
        check("ignore_no_queue", 64'(n), 64'd0);
        $display("[TB] busy-ignore mult 9*9 -> hi=%h lo=%h", hi, lo);

        // Reset in the middle of a divide
        launch(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_hi",   {32'd0, hi}, 64'd0);
        check("midreset_lo",   {32'd0, lo}, 64'd0);
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        $display("[TB] reset at E10 of div -> hi=%h lo=%h busy=%b", hi, lo, busy);

        launch(1'b1, 1'b0, 32'd6, 32'd7);
        wait_done(100, n);
        check("post_reset_latency", 64'(n), 64'd33);
        check("post_reset_hi", {32'd0, hi}, 64'd0);
        check("post_reset_lo", {32'd0, lo}, 64'd42);
        $display("[TB] post-reset mult 6*7 -> hi=%h lo=%h lat=%0d", hi, lo, n);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide responder on the far end of the control unit's `mult_start`/`div_start` strobes. It latches operands from the A and B registers, runs a 32-step radix-2 Booth multiply or a restoring divide, and presents 64-bit results on `hi`/`lo` with a one-cycle `done` pulse. The control FSM waits on `done` and then asserts `HI_write`/`LO_write`.

## Interface
- `WIDTH`, 32: operand width. Results are `WIDTH` bits each; the iteration count equals `WIDTH`.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high. Aborts any operation.
- `mult_start`, input, 1: single-cycle request for `A*B`, signed.
- `div_start`, input, 1: single-cycle request for `A/B`, signed.
- `a_in`, input, WIDTH: multiplicand or dividend. Sampled only on the accepting edge.
- `b_in`, input, WIDTH: multiplier or divisor. Sampled only on the accepting edge.
- `hi`, output, WIDTH: product[63:32] or remainder.
- `lo`, output, WIDTH: product[31:0] or quotient.
- `busy`, output, 1: high from the accepting edge until the edge that raises `done`.
- `done`, output, 1: one-cycle pulse. `hi`/`lo` are valid from this cycle onward.
- `div_zero`, output, 1: one-cycle pulse coincident with `done` on division by zero. Present only with the macro below.

## Operation
- **States:** IDLE, MULT, DIV, FIX, DZERO, DONE.
- **IDLE:**
  - `mult_start` moves the FSM to MULT and `div_start` moves it to DIV.
  - If both are high, mult wins and div is dropped.
  - Starts that arrive while `busy` is high are ignored and not queued.
- **MULT:**
  - Booth registers: {acc[W], Q[W], q_-1}.
  - Each step adds or subtracts the latched multiplicand according to {Q[0], q_-1}, then arithmetic-shifts right by 1.
  - Exactly 32 steps, then DONE.
  - Result is the full signed 64-bit product.
- **DIV:**
  - Operates on magnitudes |a| and |b|.
  - Each step shifts {R,Q} left, trial-subtracts |b| and restores if the result is negative.
  - Exactly 32 steps, then FIX.
- **FIX:**
  - Quotient is negated if sign(a) differs from sign(b), so it truncates toward zero.
  - Remainder takes the sign of a.
  - Next state is DONE.
- **DONE:**
  - `hi`/`lo` load from the internal result registers.
  - `done` is high this cycle.
  - Next state is IDLE.
- **Hold:** `hi`/`lo` keep their last result until the next DONE.
- **-2^31 / -1:** `lo`=0x80000000 (wraps), `hi`=0. No flag is raised.
- **Arithmetic widths:**
  - `acc` and `R` are WIDTH+1 bits internally for carry and sign.
  - The 2^31 magnitude of the most negative value fits unsigned in WIDTH bits.

## Timing
- Edge E0 is the edge at which the start is sampled. `busy` rises at E0.
- **Mult:** 32 iterations on E1..E32. DONE is entered at E33. `done` and updated `hi`/`lo` are visible at E33. `busy` falls at E33.
- **Div:** 32 iterations on E1..E32, FIX at E33, DONE at E34.
- **Div by zero (macro on):** DZERO at E1, DONE at E2.
- A new start is accepted at the edge where `done` falls, so back-to-back operations are possible.
- **Reset values:**
  - State IDLE.
  - `hi`=0, `lo`=0.
  - `busy`=0, `done`=0, `div_zero`=0.
  - All internal registers 0.
  - Reset mid-operation discards the partial result.

## Configuration
- **`MULT_DIV_ZERO_EXC_EN` defined:**
  - `div_start` with `b_in`==0 goes IDLE→DZERO→DONE.
  - `div_zero` pulses with `done`.
  - `hi`/`lo` stay unchanged.
  - The control unit uses `div_zero` to write EPC and take the exception.
- **Undefined:**
  - The `div_zero` port is absent and there is no detection.
  - The normal 34-cycle divide runs.
  - Result: `lo`=0xFFFFFFFF if a≥0, else 0x00000001; `hi`=a.

## Structure
- Package `mult_div_pkg` holds:
  - the state enum;
  - `WIDTH` default and iteration-count constant;
  - Booth op encoding (NOP/ADD/SUB).
- Sub-module `div_restore_step`: combinational shift, trial subtract and restore for one divide iteration. It is instantiated once and iterated by the FSM.
- Booth step and sign fix stay inline.

## Test plan
- mult a=7, b=0xFFFFFFFD (-3) → at E33 `done`=1, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `busy` falls.
- mult a=b=0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
- div a=7, b=-2 → `done` at E34, `lo`=0xFFFFFFFD, `hi`=0x00000001.
- div a=-7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- div a=0x12345678, b=0:
  - with macro: `done` and `div_zero` at E2, `hi`/`lo` unchanged;
  - without macro: `done` at E34, `lo`=0xFFFFFFFF, `hi`=0x12345678.
- mult_start and div_start in the same cycle → multiply result only. Then assert `reset` at E10 of a new div → all outputs 0 immediately, and a subsequent mult completes normally.
